// File: rtl/nibble_serial_cmp_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
package nsc_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        NSC_IDLE = 2'd0,
        NSC_RUN  = 2'd1,
        NSC_DONE = 2'd2
    } nsc_state_t;

endpackage

// File: rtl/nibble_serial_cmp_if.sv
// Operand/result valid-ready bus between reservoir state registers and readout logic.
interface nibble_serial_cmp_if #(
    parameter int unsigned WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic             out_lt;
    logic             out_gt;
    logic             out_eq;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_lt, out_gt, out_eq
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_lt, out_gt, out_eq
    );

endinterface

// File: rtl/nibble_serial_cmp_comp_4bit.sv
// 4-bit cascadable magnitude comparator; a nibble difference overrides the lower-order cascade.
module comp_4bit
    import nsc_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_lt,
    input  logic             i_gt,
    input  logic             i_eq,
    output logic             o_lt2,
    output logic             o_gt2,
    output logic             o_eq2
);

    always_comb begin
        o_lt2 = i_lt;
        o_gt2 = i_gt;
        o_eq2 = i_eq;
        if (i_a > i_b) begin
            o_lt2 = 1'b0;
            o_gt2 = 1'b1;
            o_eq2 = 1'b0;
        end else if (i_a < i_b) begin
            o_lt2 = 1'b1;
            o_gt2 = 1'b0;
            o_eq2 = 1'b0;
        end
    end

endmodule

// File: rtl/nibble_serial_cmp.sv
// Sequential WIDTH-bit unsigned comparator, one nibble per cycle, LSB nibble first.
// Optional delivered-gt statistics counter enabled by defining NSC_STATS_EN.
module nibble_serial_cmp
    import nsc_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    nibble_serial_cmp_if.slave bus
`ifdef NSC_STATS_EN
    ,
    output logic [CNT_W-1:0]   cnt_gt,
    input  logic               cnt_clr
`endif
);

    localparam int unsigned NIB       = WIDTH / NIB_W;
    localparam int unsigned NIB_CNT_W = $clog2(NIB);
    localparam logic [NIB_CNT_W-1:0] NIB_LAST = NIB_CNT_W'(NIB - 1);

    nsc_state_t           r_state;
    logic [WIDTH-1:0]     r_sh_a;
    logic [WIDTH-1:0]     r_sh_b;
    logic [NIB_CNT_W-1:0] r_nib_cnt;
    logic                 r_lt;
    logic                 r_gt;
    logic                 r_eq;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_out_lt;
    logic                 r_out_gt;
    logic                 r_out_eq;

    logic                 w_lt2;
    logic                 w_gt2;
    logic                 w_eq2;

    comp_4bit u_comp (
        .i_a   (r_sh_a[NIB_W-1:0]),
        .i_b   (r_sh_b[NIB_W-1:0]),
        .i_lt  (r_lt),
        .i_gt  (r_gt),
        .i_eq  (r_eq),
        .o_lt2 (w_lt2),
        .o_gt2 (w_gt2),
        .o_eq2 (w_eq2)
    );

    // Control FSM; the cascade flags from the last nibble are copied into the output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= NSC_IDLE;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_nib_cnt   <= '0;
            r_lt        <= 1'b0;
            r_gt        <= 1'b0;
            r_eq        <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_lt    <= 1'b0;
            r_out_gt    <= 1'b0;
            r_out_eq    <= 1'b0;
        end else begin
            case (r_state)
                NSC_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (r_in_ready && bus.in_valid) begin
                        r_sh_a     <= bus.in_a;
                        r_sh_b     <= bus.in_b;
                        r_lt       <= 1'b0;
                        r_gt       <= 1'b0;
                        r_eq       <= 1'b1;
                        r_nib_cnt  <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= NSC_RUN;
                    end
                end
                NSC_RUN: begin
                    r_lt      <= w_lt2;
                    r_gt      <= w_gt2;
                    r_eq      <= w_eq2;
                    r_sh_a    <= r_sh_a >> NIB_W;
                    r_sh_b    <= r_sh_b >> NIB_W;
                    r_nib_cnt <= r_nib_cnt + NIB_CNT_W'(1);
                    if (r_nib_cnt == NIB_LAST) begin
                        r_out_lt    <= w_lt2;
                        r_out_gt    <= w_gt2;
                        r_out_eq    <= w_eq2;
                        r_out_valid <= 1'b1;
                        r_state     <= NSC_DONE;
                    end
                end
                NSC_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_lt    <= 1'b0;
                        r_out_gt    <= 1'b0;
                        r_out_eq    <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= NSC_IDLE;
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= NSC_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_lt    = r_out_lt;
    assign bus.out_gt    = r_out_gt;
    assign bus.out_eq    = r_out_eq;

`ifdef NSC_STATS_EN
    logic [CNT_W-1:0] r_cnt_gt;
    logic             w_gt_handoff;

    assign w_gt_handoff = r_out_valid & bus.out_ready & r_out_gt;

    // Saturating count of delivered gt results; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_gt <= '0;
        end else if (cnt_clr) begin
            r_cnt_gt <= '0;
        end else if (w_gt_handoff && (r_cnt_gt != {CNT_W{1'b1}})) begin
            r_cnt_gt <= r_cnt_gt + CNT_W'(1);
        end
    end

    assign cnt_gt = r_cnt_gt;
`endif

endmodule
